mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_resp_tracker.sv | 27 ++
 rtl/mem_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: requester ownership, in-flight slot tag
// and the legal range of the fixed memory read latency.
package mem_arbiter_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_read;
  } tag_t;

  // A redirect only kills instruction slots; data slots ride through untouched.
  function automatic tag_t flush_tag(input tag_t tag, input logic flush);
    tag_t result;
    result = tag;
    if (flush && tag.owner == OWN_I) result.valid = 1'b0;
    return result;
  endfunction

endpackage

// File: rtl/mem_arbiter_resp_tracker.sv
// LAT-deep tag pipeline; the last stage names the owner of this cycle's mem_rdata.
module resp_tracker
  import mem_arbiter_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) stage[k] <= '0;
    end else begin
      stage[0] <= flush_tag(tag_in, flush);
      for (int k = 1; k < LAT; k++) stage[k] <= flush_tag(stage[k-1], flush);
    end
  end

  assign tag_out = stage[LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) round-robin arbiter onto a single fixed-latency
// memory port, with in-order response routing and a saturating conflict counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  input  logic              flush,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       conflicts
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_check
    $error("mem_arbiter: LAT out of range");
  end

  logic        prio_d;
  logic        contended;
  logic        grant_i;
  logic        grant_d;
  logic [31:0] conflict_cnt;
  tag_t        tag_in;
  tag_t        tag_out;

  assign contended = i_valid & d_valid;

  // Readies are gated by rstn so nothing can transfer while reset is held.
  always_comb begin
    grant_d   = d_valid & (~i_valid | prio_d);
    grant_i   = i_valid & (~d_valid | ~prio_d);
    i_ready   = rstn & grant_i & ~flush;
    d_ready   = rstn & grant_d;
    mem_en    = i_ready | d_ready;
    mem_addr  = d_ready ? d_addr : i_addr;
    mem_we    = d_ready ? d_we : 4'b0000;
    mem_wdata = d_wdata;
    tag_in.valid   = mem_en;
    tag_in.owner   = d_ready ? OWN_D : OWN_I;
    tag_in.is_read = d_ready ? (d_we == 4'b0000) : 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_d       <= 1'b1;
      conflict_cnt <= '0;
    end else if (contended) begin
      prio_d <= ~grant_d;
      if (conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  resp_tracker #(.LAT(LAT)) u_tracker (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign i_rvalid  = tag_out.valid & (tag_out.owner == OWN_I) & tag_out.is_read;
  assign d_rvalid  = tag_out.valid & (tag_out.owner == OWN_D) & tag_out.is_read;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign conflicts = conflict_cnt;

endmodule
